// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_unit
// Purpose  : Pipeline hazard controller for the 5-stage MIPS core. Resolves
//            RAW hazards by forwarding where possible and stalling where not
//            (load-use, branch compare in Decode, HI/LO read while a
//            multiply/divide is still in flight).
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   MULT_CYCLES  cycles from MULT/MULTU entering Execute until HI/LO valid (2..63)
//   DIV_CYCLES   cycles from DIV/DIVU entering Execute until HI/LO valid  (2..63)
// Ports
//   clk, reset                    clock, synchronous active-high reset
//   Rs/Rt_decode, Rs/Rt_execute   source register fields in Decode / Execute
//   write_reg_*, register_write_* destination + write enable per later stage
//   memory_to_register_*          load flag in Execute / Memory
//   branch_decode                 branch / JR / JALR comparing in Decode
//   hilo_access_decode            HI/LO user in Decode
//   muldiv_start_execute          MULT/DIV op in Execute, muldiv_is_div_execute
//                                 selects the divide latency
//   stall_fetch, stall_decode     hold PC and Fetch/Decode register
//   clear_execute                 bubble into Decode/Execute register
//   forward_A/B_decode            Decode comparand from Memory ALU result
//   forward_A/B_execute           ALU source: 00 regfile, 10 Memory, 01 Writeback
//   muldiv_busy                   multiply/divide countdown non-zero
//   stall_cycles (optional)       32-bit count of stalled cycles
// Optional feature macro: HAZARD_STALL_COUNTER_EN adds the stall_cycles port.
// All outputs read 0 while reset is high.
// ============================================================================
module hazard_unit #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] Rs_decode,
  input  logic [4:0] Rt_decode,
  input  logic [4:0] Rs_execute,
  input  logic [4:0] Rt_execute,
  input  logic [4:0] write_reg_execute,
  input  logic       register_write_execute,
  input  logic       memory_to_register_execute,
  input  logic [4:0] write_reg_memory,
  input  logic       register_write_memory,
  input  logic       memory_to_register_memory,
  input  logic [4:0] write_reg_writeback,
  input  logic       register_write_writeback,
  input  logic       branch_decode,
  input  logic       hilo_access_decode,
  input  logic       muldiv_start_execute,
  input  logic       muldiv_is_div_execute,
  output logic       stall_fetch,
  output logic       stall_decode,
  output logic       clear_execute,
  output logic       forward_A_decode,
  output logic       forward_B_decode,
  output logic [1:0] forward_A_execute,
  output logic [1:0] forward_B_execute,
`ifdef HAZARD_STALL_COUNTER_EN
  output logic [31:0] stall_cycles,
`endif
  output logic       muldiv_busy
);

  localparam logic [5:0] MULT_LOAD = 6'(MULT_CYCLES);
  localparam logic [5:0] DIV_LOAD  = 6'(DIV_CYCLES);

  localparam logic [1:0] FWD_REGFILE   = 2'b00;
  localparam logic [1:0] FWD_MEMORY    = 2'b10;
  localparam logic [1:0] FWD_WRITEBACK = 2'b01;

  logic [5:0] count;

  // Stage writers that can actually produce a value ($0 is never a source).
  logic ex_writes, mem_writes, wb_writes;
  assign ex_writes  = register_write_execute   && (write_reg_execute   != 5'd0);
  assign mem_writes = register_write_memory    && (write_reg_memory    != 5'd0);
  assign wb_writes  = register_write_writeback && (write_reg_writeback != 5'd0);

  logic ex_hits_decode, mem_hits_decode;
  assign ex_hits_decode  = (write_reg_execute == Rs_decode) || (write_reg_execute == Rt_decode);
  assign mem_hits_decode = (write_reg_memory  == Rs_decode) || (write_reg_memory  == Rt_decode);

  logic load_stall, branch_stall, hilo_stall, stall;

  assign load_stall = memory_to_register_execute && ex_writes && ex_hits_decode;

  // Decode compares need the value this cycle: an Execute writer or a load in
  // Memory cannot supply it yet; a Memory ALU result is forwarded instead.
  assign branch_stall = branch_decode &&
                        ((ex_writes && ex_hits_decode) ||
                         (memory_to_register_memory && (write_reg_memory != 5'd0) &&
                          mem_hits_decode));

  // count == 1 means HI/LO is ready by the time the reader reaches Execute.
  assign hilo_stall = hilo_access_decode && ((count > 6'd1) || muldiv_start_execute);

  assign stall = load_stall || branch_stall || hilo_stall;

  // Execute-stage forward selection: Memory has priority over Writeback.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (mem_writes && (write_reg_memory == src))
      fwd_sel = FWD_MEMORY;
    else if (wb_writes && (write_reg_writeback == src))
      fwd_sel = FWD_WRITEBACK;
    else
      fwd_sel = FWD_REGFILE;
  endfunction

  logic [1:0] fwd_a_ex, fwd_b_ex;
  assign fwd_a_ex = fwd_sel(Rs_execute);
  assign fwd_b_ex = fwd_sel(Rt_execute);

  logic fwd_a_dec, fwd_b_dec;
  assign fwd_a_dec = mem_writes && (write_reg_memory == Rs_decode);
  assign fwd_b_dec = mem_writes && (write_reg_memory == Rt_decode);

  // Multiply/divide occupancy countdown. A new start always reloads.
  always_ff @(posedge clk) begin
    if (reset)
      count <= 6'd0;
    else if (muldiv_start_execute)
      count <= muldiv_is_div_execute ? DIV_LOAD : MULT_LOAD;
    else if (count != 6'd0)
      count <= count - 6'd1;
  end

  // Outputs are held at 0 for the whole reset interval, including the first
  // reset cycle before the synchronous clear has taken effect.
  assign stall_fetch       = !reset && stall;
  assign stall_decode      = !reset && stall;
  assign clear_execute     = !reset && stall;
  assign forward_A_decode  = !reset && fwd_a_dec;
  assign forward_B_decode  = !reset && fwd_b_dec;
  assign forward_A_execute = reset ? FWD_REGFILE : fwd_a_ex;
  assign forward_B_execute = reset ? FWD_REGFILE : fwd_b_ex;
  assign muldiv_busy       = !reset && (count != 6'd0);

`ifdef HAZARD_STALL_COUNTER_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt <= 32'd0;
    else if (stall_decode)
      stall_cnt <= stall_cnt + 32'd1;
  end

  assign stall_cycles = reset ? 32'd0 : stall_cnt;
`endif

endmodule
`default_nettype wire
